mult_div_unit: RTL

//   Iterative multiply/divide unit with architectural HI/LO registers for the multicycle MIPS core.

---
 rtl/mult_div_unit.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, then a single sign-fix cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MULT,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_a;        // multiplicand magnitude
  logic [WIDTH-1:0]   r_b;        // divisor magnitude
  logic [2*WIDTH-1:0] r_p;        // product accumulator, low half starts as multiplier
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_q;        // dividend shifts out as quotient shifts in
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_is_div;
  logic               r_dz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_accept_mult;
  logic               w_accept_div;
  logic               w_accept_dz;
  logic               w_last;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_p_next;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_q_next;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  // Negating the most-negative value yields the same bit pattern, which is its correct unsigned magnitude.
  assign w_a_mag = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
  assign w_b_mag = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
  assign w_last  = (r_cnt == CW'(WIDTH-1));

  assign w_sum    = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
  assign w_p_next = {w_sum, r_p[WIDTH-1:1]};

  // The partial remainder stays below the divisor, so the W-bit difference is exact when w_ge.
  assign w_shift    = {r_rem, r_q[WIDTH-1]};
  assign w_ge       = (w_shift >= {1'b0, r_b});
  assign w_diff     = w_shift[WIDTH-1:0] - r_b;
  assign w_rem_next = w_ge ? w_diff : w_shift[WIDTH-1:0];
  assign w_q_next   = {r_q[WIDTH-2:0], w_ge};

  assign w_prod_fix = r_neg_q ? -r_p : r_p;
  assign w_q_fix    = r_neg_q ? -r_q : r_q;
  assign w_rem_fix  = r_neg_r ? -r_rem : r_rem;

  assign hi = r_hi;
  assign lo = r_lo;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    busy          = 1'b0;
    done          = 1'b0;
    div_zero      = 1'b0;
    w_accept_mult = 1'b0;
    w_accept_div  = 1'b0;
    w_accept_dz   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        done     = (r_state == S_DONE);
        div_zero = (r_state == S_DONE) && r_dz;
        if (mult_start) begin
          w_accept_mult = 1'b1;
          w_state_next  = S_MULT;
        end else if (div_start) begin
          if (op_b != '0) begin
            w_accept_div = 1'b1;
            w_state_next = S_DIV;
          end else begin
            w_accept_dz  = 1'b1;
            w_state_next = S_DONE;
          end
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_MULT: begin
        busy = 1'b1;
        if (w_last) w_state_next = S_FIX;
      end
      S_DIV: begin
        busy = 1'b1;
        if (w_last) w_state_next = S_FIX;
      end
      S_FIX: begin
        busy         = 1'b1;
        w_state_next = S_DONE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_p      <= '0;
      r_rem    <= '0;
      r_q      <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_div <= 1'b0;
      r_dz     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      if (w_accept_mult || w_accept_div) begin
        r_a      <= w_a_mag;
        r_b      <= w_b_mag;
        r_p      <= {{WIDTH{1'b0}}, w_b_mag};
        r_rem    <= '0;
        r_q      <= w_a_mag;
        r_neg_q  <= is_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
        r_neg_r  <= is_signed && op_a[WIDTH-1];
        r_is_div <= w_accept_div;
        r_cnt    <= '0;
        r_dz     <= 1'b0;
      end
      if (w_accept_dz) r_dz <= 1'b1;

      if (r_state == S_MULT) begin
        r_p   <= w_p_next;
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == S_DIV) begin
        r_rem <= w_rem_next;
        r_q   <= w_q_next;
        r_cnt <= r_cnt + 1'b1;
      end

      if (r_state == S_FIX) begin
        if (r_is_div) begin
          r_hi <= w_rem_fix;
          r_lo <= w_q_fix;
        end else begin
          r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
          r_lo <= w_prod_fix[WIDTH-1:0];
        end
      end

      // mthi/mtlo only reach the registers while idle, so they never collide with the FIX write.
      if (!busy && hi_we) r_hi <= wdata;
      if (!busy && lo_we) r_lo <= wdata;
    end
  end

endmodule
